// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command initiator: opcodes, data width and FSM encoding.
package alu_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_XOR  = 2'd2;
    localparam logic [1:0] OP_SHL4 = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Only add and subtract produce a meaningful carry/borrow; everything else reports 0.
    function automatic logic flagFor(input logic [1:0] op, input logic aluFlag);
        return ((op == OP_ADD) || (op == OP_SUB)) ? aluFlag : 1'b0;
    endfunction

endpackage

// File: rtl/alu_cmd_initiator.sv
// Sequential initiator driving an external 8-bit four-function ALU via cmd/rsp handshakes.
// Optional macro ALU_ZERO_FLAG_EN adds the rsp_zero output.
module alu_cmd_initiator
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_use_acc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_flag,
`ifdef ALU_ZERO_FLAG_EN
    output logic              rsp_zero,
`endif
    output logic [DATA_W-1:0] alu_data1,
    output logic [DATA_W-1:0] alu_data2,
    output logic [1:0]        alu_select,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_flag,
    output logic [DATA_W-1:0] acc,
    output logic [CNT_W-1:0]  op_count
);

    logic [1:0]        state_q,  state_d;
    logic [DATA_W-1:0] data1_q,  data1_d;
    logic [DATA_W-1:0] data2_q,  data2_d;
    logic [1:0]        sel_q,    sel_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              flag_q,   flag_d;
    logic [DATA_W-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0]  count_q,  count_d;
`ifdef ALU_ZERO_FLAG_EN
    logic              zero_q,   zero_d;
`endif

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Operand registers only move on acceptance; the response registers only in EXEC,
    // when the ALU output has had a full cycle to settle on the registered operands.
    always_comb begin
        state_d  = state_q;
        data1_d  = data1_q;
        data2_d  = data2_q;
        sel_d    = sel_q;
        result_d = result_q;
        flag_d   = flag_q;
        acc_d    = acc_q;
        count_d  = count_q;
`ifdef ALU_ZERO_FLAG_EN
        zero_d   = zero_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    data1_d = cmd_use_acc ? acc_q : cmd_a;
                    data2_d = cmd_b;
                    sel_d   = cmd_op;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = alu_result;
                flag_d   = flagFor(sel_q, alu_flag);
                acc_d    = alu_result;
                count_d  = count_q + CNT_ONE;
`ifdef ALU_ZERO_FLAG_EN
                zero_d   = (alu_result == '0);
`endif
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            data1_q  <= '0;
            data2_q  <= '0;
            sel_q    <= '0;
            result_q <= '0;
            flag_q   <= 1'b0;
            acc_q    <= '0;
            count_q  <= '0;
`ifdef ALU_ZERO_FLAG_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            sel_q    <= sel_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
`ifdef ALU_ZERO_FLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_result = result_q;
    assign rsp_flag   = flag_q;
`ifdef ALU_ZERO_FLAG_EN
    assign rsp_zero   = zero_q;
`endif
    assign alu_data1  = data1_q;
    assign alu_data2  = data2_q;
    assign alu_select = sel_q;
    assign acc        = acc_q;
    assign op_count   = count_q;

endmodule
